// File: rtl/exc_ctrl_pkg.sv
// Shared defines for the exception controller: CP0 addresses and fields, EXC_* codes, vectors.
// The optional TLB exception path is selected with the EXC_TLB_EN macro.
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_ERL = 2;
  localparam int unsigned ST_BEV = 22;

  // Bit positions inside exc_flags_i and if_exc_i
  localparam int unsigned FLAG_RI      = 0;
  localparam int unsigned FLAG_SYSCALL = 1;
  localparam int unsigned FLAG_BREAK   = 2;
  localparam int unsigned FLAG_ERET    = 3;
  localparam int unsigned FLAG_TRAP    = 4;
  localparam int unsigned FLAG_OVF     = 5;
  localparam int unsigned FLAG_ADEL_D  = 6;
  localparam int unsigned FLAG_ADES    = 7;
  localparam int unsigned FLAG_DREFILL = 8;
  localparam int unsigned FLAG_DINV    = 9;
  localparam int unsigned FLAG_MOD     = 10;
  localparam int unsigned IF_ADEL      = 0;
  localparam int unsigned IF_REFILL    = 1;
  localparam int unsigned IF_INV       = 2;

  localparam logic [31:0] EXC_NONE           = 32'd0;
  localparam logic [31:0] EXC_INT            = 32'd1;
  localparam logic [31:0] EXC_INST_ADD_ERR   = 32'd2;
  localparam logic [31:0] EXC_INST_REFILL    = 32'd3;
  localparam logic [31:0] EXC_INST_INVALID   = 32'd4;
  localparam logic [31:0] EXC_RI             = 32'd5;
  localparam logic [31:0] EXC_SYSCALL        = 32'd6;
  localparam logic [31:0] EXC_BREAK          = 32'd7;
  localparam logic [31:0] EXC_TRAP           = 32'd8;
  localparam logic [31:0] EXC_OVF            = 32'd9;
  localparam logic [31:0] EXC_ERET           = 32'd10;
  localparam logic [31:0] EXC_DATA_ADD_ERR_L = 32'd11;
  localparam logic [31:0] EXC_DATA_ADD_ERR_S = 32'd12;
  localparam logic [31:0] EXC_DATA_REFILL    = 32'd13;
  localparam logic [31:0] EXC_DATA_INVALID   = 32'd14;
  localparam logic [31:0] EXC_DATA_MODIFY    = 32'd15;

  localparam logic [11:0] VEC_REFILL       = 12'h000;
  localparam logic [11:0] VEC_GENERAL      = 12'h180;
  localparam logic [31:0] BEV_BASE_REFILL  = 32'hBFC0_0200;
  localparam logic [31:0] BEV_BASE_GENERAL = 32'hBFC0_0380;

  typedef enum logic {StIdle, StFlush} exc_state_e;

  function automatic logic is_refill(input logic [31:0] code);
    return (code == EXC_INST_REFILL) || (code == EXC_DATA_REFILL);
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 side signals of the exception controller; slave is the controller itself.
interface exc_ctrl_if;
  logic        valid_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [10:0] exc_flags_i;
  logic [2:0]  if_exc_i;
  logic [31:0] mem_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] ebase_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output valid_i, stall_i, pc_i, in_delayslot_i, exc_flags_i, if_exc_i, mem_addr_i,
           status_i, cause_i, epc_i, ebase_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o
  );

  modport slave (
    input  valid_i, stall_i, pc_i, in_delayslot_i, exc_flags_i, if_exc_i, mem_addr_i,
           status_i, cause_i, epc_i, ebase_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/exc_ctrl_prio.sv
// exc_prio: combinational priority encoder from exception flags and interrupt request
// to a single EXC_* code.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic        int_req_i,
  input  logic [10:0] exc_flags_i,
  input  logic [2:0]  if_exc_i,
  output logic [31:0] excepttype_o
);

  always_comb begin
    excepttype_o = EXC_NONE;
    if (int_req_i)                       excepttype_o = EXC_INT;
    else if (if_exc_i[IF_ADEL])          excepttype_o = EXC_INST_ADD_ERR;
    else if (if_exc_i[IF_REFILL])        excepttype_o = EXC_INST_REFILL;
    else if (if_exc_i[IF_INV])           excepttype_o = EXC_INST_INVALID;
    else if (exc_flags_i[FLAG_RI])       excepttype_o = EXC_RI;
    else if (exc_flags_i[FLAG_SYSCALL])  excepttype_o = EXC_SYSCALL;
    else if (exc_flags_i[FLAG_BREAK])    excepttype_o = EXC_BREAK;
    else if (exc_flags_i[FLAG_TRAP])     excepttype_o = EXC_TRAP;
    else if (exc_flags_i[FLAG_OVF])      excepttype_o = EXC_OVF;
    else if (exc_flags_i[FLAG_ERET])     excepttype_o = EXC_ERET;
    else if (exc_flags_i[FLAG_ADEL_D])   excepttype_o = EXC_DATA_ADD_ERR_L;
    else if (exc_flags_i[FLAG_ADES])     excepttype_o = EXC_DATA_ADD_ERR_S;
    else if (exc_flags_i[FLAG_DREFILL])  excepttype_o = EXC_DATA_REFILL;
    else if (exc_flags_i[FLAG_DINV])     excepttype_o = EXC_DATA_INVALID;
    else if (exc_flags_i[FLAG_MOD])      excepttype_o = EXC_DATA_MODIFY;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller at the MEM/commit boundary: prioritises exceptions, issues a one-cycle
// registered flush with redirect PC. Define EXC_TLB_EN to enable the TLB exception causes.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic        clk,
  input logic        rst,
  exc_ctrl_if.slave  bus
);

  exc_state_e  state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] status_fwd, epc_fwd, prio_code, exc_code, target;
  logic [7:0]  cause_ip;
  logic [10:0] flags;
  logic [2:0]  if_exc;
  logic        int_req, commit, refill;
  logic        unused_cp0;

  // Forward CP0 writes committing in WB this cycle
  assign status_fwd = (bus.cp0_we_i && bus.cp0_waddr_i == CP0_STATUS) ? bus.cp0_wdata_i
                                                                       : bus.status_i;
  assign cause_ip   = (bus.cp0_we_i && bus.cp0_waddr_i == CP0_CAUSE) ? bus.cp0_wdata_i[15:8]
                                                                      : bus.cause_i[15:8];
  assign epc_fwd    = (bus.cp0_we_i && bus.cp0_waddr_i == CP0_EPC) ? bus.cp0_wdata_i
                                                                    : bus.epc_i;
  assign unused_cp0 = ^{status_fwd, bus.cause_i, bus.ebase_i[11:0]};

  assign int_req = status_fwd[ST_IE] & ~status_fwd[ST_EXL] & ~status_fwd[ST_ERL] &
                   |(status_fwd[15:8] & cause_ip);

`ifdef EXC_TLB_EN
  assign flags  = bus.exc_flags_i;
  assign if_exc = bus.if_exc_i;
  assign refill = is_refill(exc_code) & ~status_fwd[ST_EXL];
`else
  assign flags  = bus.exc_flags_i & 11'b000_1111_1111;
  assign if_exc = bus.if_exc_i & 3'b001;
  assign refill = 1'b0;
`endif

  exc_prio u_prio (
    .int_req_i    (int_req),
    .exc_flags_i  (flags),
    .if_exc_i     (if_exc),
    .excepttype_o (prio_code)
  );

  assign commit   = bus.valid_i & ~bus.stall_i & (state_q == StIdle);
  assign exc_code = commit ? prio_code : EXC_NONE;

  always_comb begin
    target = {bus.ebase_i[31:12], refill ? VEC_REFILL : VEC_GENERAL};
    if (exc_code == EXC_ERET) begin
      target = epc_fwd;
    end else if (status_fwd[ST_BEV]) begin
      target = refill ? BEV_BASE_REFILL : BEV_BASE_GENERAL;
    end
  end

  always_comb begin
    bus.bad_addr_o = '0;
    case (exc_code)
      EXC_INST_ADD_ERR, EXC_INST_REFILL, EXC_INST_INVALID:
        bus.bad_addr_o = bus.pc_i;
      EXC_DATA_ADD_ERR_L, EXC_DATA_ADD_ERR_S, EXC_DATA_REFILL, EXC_DATA_INVALID,
      EXC_DATA_MODIFY:
        bus.bad_addr_o = bus.mem_addr_i;
      default: bus.bad_addr_o = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    unique case (state_q)
      StIdle: begin
        if (commit && exc_code != EXC_NONE) begin
          state_d  = StFlush;
          new_pc_d = target;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      new_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign bus.excepttype_o        = exc_code;
  assign bus.current_inst_addr_o = bus.pc_i;
  assign bus.is_in_delayslot_o   = bus.in_delayslot_i;
  assign bus.flush_o             = (state_q == StFlush);
  assign bus.new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: per-cycle reference model plus directed literal checks.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exc_ctrl_if ifc ();

  exc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_flush;
  logic [31:0] m_pc;
  bit          m_live = 1'b0;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
    return (ifc.cp0_we_i && ifc.cp0_waddr_i == a) ? ifc.cp0_wdata_i : v;
  endfunction

  function automatic logic [31:0] m_code();
    logic [31:0] st, ca;
    logic [10:0] f;
    logic [2:0]  ie;
    bit          tlb, ir;
    bit          hit [15];
    logic [31:0] codes [15];
`ifdef EXC_TLB_EN
    tlb = 1'b1;
`else
    tlb = 1'b0;
`endif
    if (!(ifc.valid_i && !ifc.stall_i && !m_flush)) return 32'd0;
    st = fwd(5'd12, ifc.status_i);
    ca = fwd(5'd13, ifc.cause_i);
    f  = ifc.exc_flags_i;
    ie = ifc.if_exc_i;
    ir = st[0] && !st[1] && !st[2] && ((st[15:8] & ca[15:8]) != 8'd0);
    hit = '{ir, ie[0], tlb && ie[1], tlb && ie[2], f[0], f[1], f[2], f[4], f[5], f[3],
            f[6], f[7], tlb && f[8], tlb && f[9], tlb && f[10]};
    codes = '{EXC_INT, EXC_INST_ADD_ERR, EXC_INST_REFILL, EXC_INST_INVALID, EXC_RI,
              EXC_SYSCALL, EXC_BREAK, EXC_TRAP, EXC_OVF, EXC_ERET, EXC_DATA_ADD_ERR_L,
              EXC_DATA_ADD_ERR_S, EXC_DATA_REFILL, EXC_DATA_INVALID, EXC_DATA_MODIFY};
    for (int i = 0; i < 15; i++) if (hit[i]) return codes[i];
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_bad(input logic [31:0] c);
    if (c == EXC_INST_ADD_ERR || c == EXC_INST_REFILL || c == EXC_INST_INVALID) return ifc.pc_i;
    if (c >= EXC_DATA_ADD_ERR_L && c <= EXC_DATA_MODIFY) return ifc.mem_addr_i;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] c);
    logic [31:0] st;
    bit          rf;
    st = fwd(5'd12, ifc.status_i);
    if (c == EXC_ERET) return fwd(5'd14, ifc.epc_i);
    rf = (c == EXC_INST_REFILL || c == EXC_DATA_REFILL) && !st[1];
    if (st[22]) return rf ? 32'hBFC0_0200 : 32'hBFC0_0380;
    return {ifc.ebase_i[31:12], rf ? 12'h000 : 12'h180};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_flush <= 1'b0;
      m_pc    <= RST_PC;
      m_live  <= 1'b1;
    end else if (m_flush) begin
      m_flush <= 1'b0;
    end else if (m_code() != 32'd0) begin
      m_flush <= 1'b1;
      m_pc    <= m_target(m_code());
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [31:0] c;
      c = m_code();
      check("m_excepttype", ifc.excepttype_o, c);
      check("m_bad_addr", ifc.bad_addr_o, m_bad(c));
      check("m_cur_addr", ifc.current_inst_addr_o, ifc.pc_i);
      check("m_dslot", {31'd0, ifc.is_in_delayslot_o}, {31'd0, ifc.in_delayslot_i});
      check("m_flush", {31'd0, ifc.flush_o}, {31'd0, m_flush});
      check("m_new_pc", ifc.new_pc_o, m_pc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    ifc.valid_i        = 1'b0;
    ifc.stall_i        = 1'b0;
    ifc.pc_i           = 32'h8000_1000;
    ifc.in_delayslot_i = 1'b0;
    ifc.exc_flags_i    = '0;
    ifc.if_exc_i       = '0;
    ifc.mem_addr_i     = '0;
    ifc.status_i       = '0;
    ifc.cause_i        = '0;
    ifc.epc_i          = '0;
    ifc.ebase_i        = 32'h8000_0000;
    ifc.cp0_we_i       = 1'b0;
    ifc.cp0_waddr_i    = '0;
    ifc.cp0_wdata_i    = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Inputs already applied in cycle N: check N, flush in N+1 only.
  task automatic fire(input string nm, input logic [31:0] code, input logic [31:0] bad,
                      input logic [31:0] pc);
    smp();
    check({nm, "_code"}, ifc.excepttype_o, code);
    check({nm, "_bad"}, ifc.bad_addr_o, bad);
    nxt();
    clr();
    smp();
    check({nm, "_flush"}, {31'd0, ifc.flush_o}, 32'd1);
    check({nm, "_pc"}, ifc.new_pc_o, pc);
    nxt();
    smp();
    check({nm, "_unflush"}, {31'd0, ifc.flush_o}, 32'd0);
    check({nm, "_pc_hold"}, ifc.new_pc_o, pc);
    nxt();
  endtask

  initial begin
    clr();
    rst = 1'b0;
    repeat (2) nxt();
    smp();
    check("rst_flush", {31'd0, ifc.flush_o}, 32'd0);
    check("rst_pc", ifc.new_pc_o, 32'hBFC0_0000);
    nxt();
    rst = 1'b1;
    nxt();

    // Syscall, general vector from EBase
    ifc.valid_i = 1'b1; ifc.pc_i = 32'h8000_1000; ifc.exc_flags_i = 11'h002;
    ifc.in_delayslot_i = 1'b1;
    fire("sys", EXC_SYSCALL, 32'd0, 32'h8000_0180);

    // Interrupt beats overflow; with EXL set overflow wins
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h020;
    ifc.status_i = 32'h0000_0401; ifc.cause_i = 32'h0000_0400;
    fire("int", EXC_INT, 32'd0, 32'h8000_0180);
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h020;
    ifc.status_i = 32'h0000_0403; ifc.cause_i = 32'h0000_0400;
    fire("ovf", EXC_OVF, 32'd0, 32'h8000_0180);

    // ERET with EPC forwarded from WB
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h008; ifc.epc_i = 32'h0;
    ifc.cp0_we_i = 1'b1; ifc.cp0_waddr_i = 5'd14; ifc.cp0_wdata_i = 32'h8000_2000;
    fire("eret", EXC_ERET, 32'd0, 32'h8000_2000);

    // BEV=1 general vector
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h002; ifc.status_i = 32'h0040_0000;
    fire("bev", EXC_SYSCALL, 32'd0, 32'hBFC0_0380);

    // Instruction address error outranks RI, bad_addr is the PC
    ifc.valid_i = 1'b1; ifc.pc_i = 32'h8000_0a02; ifc.if_exc_i = 3'b001;
    ifc.exc_flags_i = 11'h001;
    fire("adeli", EXC_INST_ADD_ERR, 32'h8000_0a02, 32'h8000_0180);

    // Load address error, bad_addr is the data address
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h040; ifc.mem_addr_i = 32'h0000_1003;
    fire("adeld", EXC_DATA_ADD_ERR_L, 32'h0000_1003, 32'h8000_0180);

    // Data TLB refill
`ifdef EXC_TLB_EN
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h100; ifc.mem_addr_i = 32'h0040_0000;
    fire("drefill", EXC_DATA_REFILL, 32'h0040_0000, 32'h8000_0000);
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h100; ifc.mem_addr_i = 32'h0040_0000;
    ifc.status_i = 32'h0000_0002;
    fire("drefill_exl", EXC_DATA_REFILL, 32'h0040_0000, 32'h8000_0180);
`else
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h100; ifc.mem_addr_i = 32'h0040_0000;
    smp();
    check("notlb_code", ifc.excepttype_o, 32'd0);
    nxt();
    clr();
    smp();
    check("notlb_flush", {31'd0, ifc.flush_o}, 32'd0);
    nxt();
`endif

    // Stall holds off the RI until the first unstalled cycle
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h001; ifc.pc_i = 32'h8000_3000;
    ifc.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("stall_code", ifc.excepttype_o, 32'd0);
      check("stall_flush", {31'd0, ifc.flush_o}, 32'd0);
      nxt();
    end
    ifc.stall_i = 1'b0;
    fire("stall_ri", EXC_RI, 32'd0, 32'h8000_0180);

    // Back-to-back fault in N+1 is squashed
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h002;
    smp();
    check("b2b_first", ifc.excepttype_o, EXC_SYSCALL);
    nxt();
    ifc.exc_flags_i = 11'h001; ifc.pc_i = 32'h8000_1004;
    smp();
    check("b2b_second", ifc.excepttype_o, 32'd0);
    check("b2b_flush", {31'd0, ifc.flush_o}, 32'd1);
    nxt();
    clr();
    smp();
    check("b2b_noflush", {31'd0, ifc.flush_o}, 32'd0);
    nxt();

    // Reset during FLUSH
    ifc.valid_i = 1'b1; ifc.exc_flags_i = 11'h002;
    nxt();
    rst = 1'b0;
    smp();
    check("rstf_flush_on", {31'd0, ifc.flush_o}, 32'd1);
    nxt();
    rst = 1'b1;
    clr();
    smp();
    check("rstf_flush", {31'd0, ifc.flush_o}, 32'd0);
    check("rstf_pc", ifc.new_pc_o, 32'hBFC0_0000);
    repeat (2) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
